alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe_if.sv | 27 ++
 rtl/alu_pipe.sv | 192 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Request/response bundle for alu_pipe.
// The master drives requests and result acceptance; the slave (the ALU) drives the rest.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             zero;
  logic             ovf;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, res, zero, ovf, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, res, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU with a one-deep registered result and valid/ready handshakes.
// Single-cycle ops complete on the accept edge. With ALU_PIPE_MUL_EN defined, op 7 runs an
// iterative shift-add multiply (one partial product per cycle); without it op 7 is flagged
// illegal and returns zero.
module alu_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);

  // The multiplier retires exactly one operand bit per iteration.
  if (MUL_CYCLES != WIDTH) begin : g_bad_cfg
    $error("alu_pipe: MUL_CYCLES must equal WIDTH");
  end

  localparam logic [WIDTH-1:0] One = WIDTH'(1);
  localparam int unsigned      Msb = WIDTH - 1;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;
  localparam int unsigned CntW    = $clog2(MUL_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(MUL_CYCLES - 1);
`else
  typedef enum logic [0:0] {StIdle, StHold} state_e;
`endif

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_res, w_res_d;
  logic             r_ovf, w_ovf_d;
  logic             r_illegal, w_illegal_d;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum, w_diff, w_alu_res;
  logic             w_slt, w_sltu, w_alu_ovf, w_alu_ill;

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0] r_mcand, w_mcand_d;
  logic [WIDTH-1:0] r_mplier, w_mplier_d;
  logic [WIDTH-1:0] r_acc, w_acc_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             w_is_mul;
  assign w_is_mul = (bus.op == 3'd7);
`endif

  // Ready is forced low while reset is held; otherwise set by the state.
  always_comb begin
    w_in_ready = 1'b0;
    if (!rst) begin
      case (r_state)
        StIdle:  w_in_ready = 1'b1;
        StHold:  w_in_ready = bus.out_ready;
        default: w_in_ready = 1'b0;
      endcase
    end
  end

  assign w_accept = bus.in_valid && w_in_ready;

  // Single-cycle result for the incoming request.
  always_comb begin
    w_sum     = bus.a + bus.b;
    w_diff    = bus.a + ~bus.b + One;
    // Direct signed compare stays correct even when a - b overflows.
    w_slt     = $signed(bus.a) < $signed(bus.b);
    w_sltu    = bus.a < bus.b;
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_ill = 1'b0;
    case (bus.op)
      3'd0: w_alu_res = bus.a & bus.b;
      3'd1: w_alu_res = bus.a | bus.b;
      3'd2: begin
        w_alu_res = w_sum;
        w_alu_ovf = (bus.a[Msb] == bus.b[Msb]) && (w_sum[Msb] != bus.a[Msb]);
      end
      3'd3: begin
        w_alu_res = w_diff;
        w_alu_ovf = (bus.a[Msb] != bus.b[Msb]) && (w_diff[Msb] != bus.a[Msb]);
      end
      3'd4: w_alu_res = {{(WIDTH-1){1'b0}}, w_slt};
      3'd5: w_alu_res = {{(WIDTH-1){1'b0}}, w_sltu};
      3'd6: w_alu_res = ~(bus.a | bus.b);
      default: begin
`ifdef ALU_PIPE_MUL_EN
        w_alu_ill = 1'b0;
`else
        w_alu_ill = 1'b1;
`endif
      end
    endcase
  end

  // Next state and next datapath values.
  always_comb begin
    w_state_d   = r_state;
    w_res_d     = r_res;
    w_ovf_d     = r_ovf;
    w_illegal_d = r_illegal;
`ifdef ALU_PIPE_MUL_EN
    w_mcand_d   = r_mcand;
    w_mplier_d  = r_mplier;
    w_acc_d     = r_acc;
    w_cnt_d     = r_cnt;
`endif
    case (r_state)
      StIdle, StHold: begin
        if (w_accept) begin
`ifdef ALU_PIPE_MUL_EN
          if (w_is_mul) begin
            w_state_d  = StBusy;
            w_mcand_d  = bus.a;
            w_mplier_d = bus.b;
            w_acc_d    = '0;
            w_cnt_d    = '0;
          end else begin
            w_state_d   = StHold;
            w_res_d     = w_alu_res;
            w_ovf_d     = w_alu_ovf;
            w_illegal_d = w_alu_ill;
          end
`else
          w_state_d   = StHold;
          w_res_d     = w_alu_res;
          w_ovf_d     = w_alu_ovf;
          w_illegal_d = w_alu_ill;
`endif
        end else if ((r_state == StHold) && bus.out_ready) begin
          w_state_d = StIdle;
        end
      end
`ifdef ALU_PIPE_MUL_EN
      StBusy: begin
        w_acc_d    = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_mcand_d  = r_mcand << 1;
        w_mplier_d = r_mplier >> 1;
        w_cnt_d    = r_cnt + 1'b1;
        if (r_cnt == LastCnt) begin
          w_state_d   = StHold;
          w_res_d     = w_acc_d;
          w_ovf_d     = 1'b0;
          w_illegal_d = 1'b0;
        end
      end
`endif
      default: w_state_d = StIdle;
    endcase
  end

  // State and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_res     <= '0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_res     <= w_res_d;
      r_ovf     <= w_ovf_d;
      r_illegal <= w_illegal_d;
    end
  end

`ifdef ALU_PIPE_MUL_EN
  // Multiplier working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_acc    <= w_acc_d;
      r_cnt    <= w_cnt_d;
    end
  end
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == StHold);
  assign bus.res       = r_res;
  assign bus.zero      = (r_res == '0);
  assign bus.ovf       = r_ovf;
  assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed table, handshake sequences,
// reset aborts and randomized traffic against an arithmetic reference model.
module tb_alu_pipe;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W), .MUL_CYCLES(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        ill;
  } model_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bus.in_valid = v;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic model_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    model_t m;
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m  = '0;
    case (op)
      3'd0: m.res = a & b;
      3'd1: m.res = a | b;
      3'd2: begin
        s = sa + sb;
        m.res = a + b;
        m.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd3: begin
        s = sa - sb;
        m.res = a - b;
        m.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd4: m.res = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: m.res = (a < b) ? 32'd1 : 32'd0;
      3'd6: m.res = ~(a | b);
      default: begin
`ifdef ALU_PIPE_MUL_EN
        p = {32'd0, a} * {32'd0, b};
        m.res = p[31:0];
`else
        p = '0;
        m.ill = 1'b1;
`endif
      end
    endcase
    return m;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] specials[5];
    logic [31:0] hold_res;
    model_t      m;
    int          lat, exp_lat, stall;
    logic        seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    specials[0] = 32'h0000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h0000_0001;

    vecs[0]  = '{"add_ovf",   3'd2, 32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 1'b1};
    vecs[1]  = '{"sub_zero",  3'd3, 32'h5,         32'h5,          32'h0,         1'b1, 1'b0};
    vecs[2]  = '{"slt_neg",   3'd4, 32'h8000_0000, 32'h1,          32'h1,         1'b0, 1'b0};
    vecs[3]  = '{"sltu_neg",  3'd5, 32'h8000_0000, 32'h1,          32'h0,         1'b1, 1'b0};
    vecs[4]  = '{"and",       3'd0, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000, 1'b0, 1'b0};
    vecs[5]  = '{"or",        3'd1, 32'hF0F0_F0F0, 32'h0F0F_0000,  32'hFFFF_F0F0, 1'b0, 1'b0};
    vecs[6]  = '{"nor",       3'd6, 32'h0,         32'h0,          32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{"sub_ovf",   3'd3, 32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[8]  = '{"add_wrap",  3'd2, 32'hFFFF_FFFF, 32'h1,          32'h0,         1'b1, 1'b0};
    vecs[9]  = '{"slt_ovf0",  3'd4, 32'h7FFF_FFFF, 32'h8000_0000,  32'h0,         1'b1, 1'b0};
    vecs[10] = '{"slt_ovf1",  3'd4, 32'h8000_0000, 32'h7FFF_FFFF,  32'h1,         1'b0, 1'b0};
    vecs[11] = '{"sub_min",   3'd3, 32'h0,         32'h8000_0000,  32'h8000_0000, 1'b0, 1'b1};
    vecs[12] = '{"add_plain", 3'd2, 32'h2,         32'h3,          32'h5,         1'b0, 1'b0};

    // Reset values while reset is held.
    rst = 1'b1;
    drive(1'b1, 3'd2, 32'h1, 32'h1);
    bus.out_ready = 1'b1;
    #3;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_res",       64'(bus.res),       64'd0);
    check("rst_zero",      64'(bus.zero),      64'd1);
    check("rst_ovf",       64'(bus.ovf),       64'd0);
    check("rst_illegal",   64'(bus.illegal),   64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    tick();
    tick();
    check("rst_no_accept", 64'(bus.out_valid), 64'd0);
    rst = 1'b0;

    // Directed table; first entry is accepted on the first edge after reset release.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      tick();
      bus.in_valid = 1'b0;
      check({vecs[i].name, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({vecs[i].name, "_res"},   64'(bus.res),       64'(vecs[i].res));
      check({vecs[i].name, "_zero"},  64'(bus.zero),      64'(vecs[i].zero));
      check({vecs[i].name, "_ovf"},   64'(bus.ovf),       64'(vecs[i].ovf));
      check({vecs[i].name, "_ill"},   64'(bus.illegal),   64'd0);
    end
    tick();
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // Back-to-back stream, then consumer stall.
    drive(1'b1, 3'd0, 32'hF0F0_F0F0, 32'h3C3C_3C3C);
    tick();
    drive(1'b1, 3'd1, 32'h1234_5678, 32'h0F0F_0000);
    settle();
    check("stream_and_valid", 64'(bus.out_valid), 64'd1);
    check("stream_and_res",   64'(bus.res),       64'h3030_3030);
    check("stream_in_ready",  64'(bus.in_ready),  64'd1);
    tick();
    drive(1'b1, 3'd6, 32'hFFFF_0000, 32'h0000_FF00);
    check("stream_or_valid",  64'(bus.out_valid), 64'd1);
    check("stream_or_res",    64'(bus.res),       64'h1F3F_5678);
    tick();
    check("stream_nor_res",   64'(bus.res),       64'h0000_00FF);
    drive(1'b1, 3'd2, 32'h1, 32'h1);
    bus.out_ready = 1'b0;
    settle();
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_valid",    64'(bus.out_valid), 64'd1);
      check("stall_res",      64'(bus.res),       64'h0000_00FF);
      check("stall_in_ready", 64'(bus.in_ready),  64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("stall_release_valid", 64'(bus.out_valid), 64'd0);

    // Reset while holding a result discards it.
    drive(1'b1, 3'd2, 32'h1, 32'h1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("hold_before_rst", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    settle();
    check("hold_rst_valid", 64'(bus.out_valid), 64'd0);
    check("hold_rst_res",   64'(bus.res),       64'd0);
    check("hold_rst_zero",  64'(bus.zero),      64'd1);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("hold_rst_after", 64'(bus.out_valid), 64'd0);

`ifdef ALU_PIPE_MUL_EN
    // Multiply latency; an ADD waits on in_valid throughout.
    drive(1'b1, 3'd7, 32'h0001_0001, 32'h0001_0001);
    tick();
    drive(1'b1, 3'd2, 32'h2, 32'h3);
    bus.out_ready = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (bus.in_ready || bus.out_valid) seen = 1'b1;
      tick();
    end
    check("mul_busy_quiet", 64'(seen),          64'd0);
    check("mul_valid_33",   64'(bus.out_valid), 64'd1);
    check("mul_res",        64'(bus.res),       64'h0002_0001);
    check("mul_illegal",    64'(bus.illegal),   64'd0);
    bus.out_ready = 1'b1;
    settle();
    check("mul_hold_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check("mul_next_add", 64'(bus.res), 64'd5);
    tick();

    // Reset mid-multiply aborts it.
    drive(1'b1, 3'd7, 32'h0001_0001, 32'h0001_0001);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    settle();
    check("mulrst_valid", 64'(bus.out_valid), 64'd0);
    check("mulrst_res",   64'(bus.res),       64'd0);
    check("mulrst_zero",  64'(bus.zero),      64'd1);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    check("mulrst_no_result", 64'(seen), 64'd0);
    drive(1'b1, 3'd2, 32'h2, 32'h3);
    tick();
    bus.in_valid = 1'b0;
    check("mulrst_add_res", 64'(bus.res), 64'd5);
    tick();
`else
    // Op 7 is illegal in this build.
    drive(1'b1, 3'd7, 32'h0001_0001, 32'h0001_0001);
    tick();
    bus.in_valid = 1'b0;
    check("mul_ill_valid", 64'(bus.out_valid), 64'd1);
    check("mul_ill_flag",  64'(bus.illegal),   64'd1);
    check("mul_ill_res",   64'(bus.res),       64'd0);
    check("mul_ill_zero",  64'(bus.zero),      64'd1);
    tick();
`endif

    // Randomized traffic with random consumer stalls.
    for (int n = 0; n < 300; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
      rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
      m   = model(rop, ra, rb);
`ifdef ALU_PIPE_MUL_EN
      exp_lat = (rop == 3'd7) ? 33 : 1;
`else
      exp_lat = 1;
`endif
      bus.out_ready = 1'b1;
      drive(1'b1, rop, ra, rb);
      settle();
      check("rnd_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
        tick();
        lat++;
      end
      check("rnd_latency", 64'(lat),         64'(exp_lat));
      check("rnd_res",     64'(bus.res),     64'(m.res));
      check("rnd_zero",    64'(bus.zero),    64'(m.res == 32'd0));
      check("rnd_ovf",     64'(bus.ovf),     64'(m.ovf));
      check("rnd_illegal", 64'(bus.illegal), 64'(m.ill));
      stall = $urandom_range(0, 2);
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        hold_res = m.res;
        repeat (stall) tick();
        check("rnd_stall_valid", 64'(bus.out_valid), 64'd1);
        check("rnd_stall_res",   64'(bus.res),       64'(hold_res));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
